// File: rtl/pwl_activation_pipe.sv
// Pipelined fixed-point activation unit: tanh (piecewise-linear over an
// elaboration-time node table), sigmoid via tanh(x/2), identity and ReLU.
// DIM lanes per beat, one shared valid/ready stream, fixed latency of 3.

// One lane of the datapath; valid/ready bookkeeping lives in the top.
module pwl_lane #(
   parameter int WIDTH     = 16,
   parameter int FRAC      = 8,
   parameter int SEG_BITS  = 5,
   parameter int XMAX_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y
);
   localparam int OFF   = FRAC + XMAX_LOG2 - SEG_BITS;
   localparam int AW    = FRAC + XMAX_LOG2;
   localparam int NODES = 2**SEG_BITS + 1;
   localparam int PW    = WIDTH + OFF + 2;
   localparam int TW    = WIDTH + 2;
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   typedef logic [NODES-1:0][WIDTH-1:0] tbl_t;

   // Nodes at k*2^OFF LSBs, rounded half away from zero (all are >= 0);
   // the last node is pinned to 1.0 so the saturated region joins cleanly.
   function automatic tbl_t build_tbl();
      tbl_t tb;
      real  xv, e2, th;
      tb = '0;
      for (int k = 0; k < NODES; k++) begin
         xv = real'(k) * real'(2**OFF) / real'(2**FRAC);
         e2 = $exp(2.0 * xv);
         th = (e2 - 1.0) / (e2 + 1.0) * real'(2**FRAC);
         tb[k] = WIDTH'($rtoi(th + 0.5));
      end
      tb[NODES-1] = WIDTH'(2**FRAC);
      return tb;
   endfunction

   localparam tbl_t TBL = build_tbl();

   logic [1:0]              s0_mode, s1_mode, s2_mode;
   logic signed [WIDTH-1:0] s0_x, s1_x, s2_x;
   logic signed [WIDTH-1:0] xp;
   logic [WIDTH-1:0]        am;
   logic [SEG_BITS-1:0]     s1_k;
   logic [OFF-1:0]          s1_off, s2_off;
   logic                    s1_sign, s1_sat, s2_sign, s2_sat;
   logic [SEG_BITS:0]       k0, k1;
   logic signed [WIDTH-1:0] s2_node, s2_d;
   logic signed [PW-1:0]    prod;
   logic signed [TW-1:0]    tm, ts, sg, res;

   // Input capture on the accept edge
   always_ff @(posedge clk) begin
      if (adv) begin
         s0_mode <= mode;
         s0_x    <= x;
      end
   end

   // Sigmoid argument pre-scale and magnitude; the most negative value
   // has no positive twin, so it clamps (it saturates the table anyway)
   always_comb begin
      xp = (s0_mode == 2'b01) ? (s0_x >>> 1) : s0_x;
      if (xp == MINV)          am = ~MINV;
      else if (xp[WIDTH-1])    am = WIDTH'(-xp);
      else                     am = xp;
   end

   // Stage 1: segment index, in-segment offset, sign and saturation
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_k    <= am[AW-1:OFF];
         s1_off  <= am[OFF-1:0];
         s1_sign <= xp[WIDTH-1];
         s1_sat  <= |am[WIDTH-1:AW];
         s1_mode <= s0_mode;
         s1_x    <= s0_x;
      end
   end

   // Table addresses for the segment's two end nodes
   always_comb begin
      k0 = {1'b0, s1_k};
      k1 = k0 + (SEG_BITS+1)'(1);
   end

   // Stage 2: node value and segment slope
   always_ff @(posedge clk) begin
      if (adv) begin
         s2_node <= $signed(TBL[k0]);
         s2_d    <= $signed(TBL[k1]) - $signed(TBL[k0]);
         s2_off  <= s1_off;
         s2_sign <= s1_sign;
         s2_sat  <= s1_sat;
         s2_mode <= s1_mode;
         s2_x    <= s1_x;
      end
   end

   // Interpolate, restore sign, then pick the per-beat activation
   always_comb begin
      prod = PW'(s2_d) * PW'($signed({1'b0, s2_off})) + PW'(2**(OFF-1));
      tm   = s2_sat ? TW'(2**FRAC) : TW'(s2_node) + TW'(prod >>> OFF);
      ts   = s2_sign ? -tm : tm;
      sg   = (TW'(2**FRAC) + ts + TW'(1)) >>> 1;
      case (s2_mode)
         2'b00:   res = ts;
         2'b01:   res = sg;
         2'b10:   res = TW'(s2_x);
         default: res = s2_x[WIDTH-1] ? '0 : TW'(s2_x);
      endcase
   end

   // Stage 3: output register, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst)      y <= '0;
      else if (adv) y <= WIDTH'(res);
   end
endmodule

module pwl_activation_pipe #(
   parameter int DIM       = 1,
   parameter int WIDTH     = 16,
   parameter int FRAC      = 8,
   parameter int SEG_BITS  = 5,
   parameter int XMAX_LOG2 = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_mode,
   input  logic [DIM*WIDTH-1:0] in_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DIM*WIDTH-1:0] out_vec
);
   localparam int STAGES = 3;

   logic                       adv;
   logic [STAGES:0]            vld_pipe;
   logic [DIM-1:0][WIDTH-1:0]  lane_x, lane_y;

   // Whole pipe moves in lockstep; bubbles advance too
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[STAGES];
   assign lane_x    = in_vec;
   assign out_vec   = lane_y;

   // Valid shift register tracking the beats in flight
   always_ff @(posedge clk) begin
      if (rst)      vld_pipe <= '0;
      else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
   end

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      pwl_lane #(
         .WIDTH     (WIDTH),
         .FRAC      (FRAC),
         .SEG_BITS  (SEG_BITS),
         .XMAX_LOG2 (XMAX_LOG2)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .adv  (adv),
         .mode (in_mode),
         .x    (lane_x[i]),
         .y    (lane_y[i])
      );
   end
endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Bench for pwl_activation_pipe (DIM=4, Q8.8): directed literals, reset
// flush, backpressure, full throughput and an exhaustive tanh/sigmoid sweep.
module tb_pwl_activation_pipe;
   localparam int DIM = 4;
   localparam int W   = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [1:0]         in_mode = 2'd0;
   logic [DIM*W-1:0]   in_vec = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [DIM*W-1:0]   out_vec;

   always #5 clk = ~clk;

   pwl_activation_pipe #(.DIM(DIM), .WIDTH(W), .FRAC(8), .SEG_BITS(5), .XMAX_LOG2(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec));

   typedef struct { logic [63:0] vin; logic [1:0] m; logic [63:0] exp; int acc; } ent_t;

   int          checks = 0, failures = 0, cyc = 0, pops = 0;
   int          nodes [0:32];
   ent_t        sb [$];
   bit          lat_chk = 1'b0, sweep_on = 1'b0, rand_rdy = 1'b0, hold_pend = 1'b0;
   logic [63:0] hold_vec;
   logic [15:0] tanh_res [0:65535];
   int          max_err_t = 0, max_err_s = 0;

   task automatic fail(input string nm, input logic [63:0] act, input logic [63:0] req);
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
   endtask

   function automatic int rnd(input real v);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Reference: table lookup + linear interpolation straight from the rules
   function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] x);
      int xs, a, t, k, f;
      xs = int'($signed(x));
      if (m == 2'd1) xs = xs >>> 1;
      a = (xs < 0) ? -xs : xs;
      if (a > 32767) a = 32767;
      if (a >= 1024) t = 256;
      else begin
         k = a / 32;
         f = a % 32;
         t = nodes[k] + ((nodes[k+1] - nodes[k]) * f + 16) / 32;
      end
      if (xs < 0) t = -t;
      case (m)
         2'd0:    return 16'(t);
         2'd1:    return 16'((257 + t) / 2);
         2'd2:    return x;
         default: return ($signed(x) < 0) ? 16'h0000 : x;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push on accept, compare on every output transfer
   always @(negedge clk) begin
      ent_t e;
      int   xi, yi, id, err;
      if (rst) begin
         sb.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (!(out_valid === 1'b1 && out_vec === hold_vec)) fail("stall_hold", out_vec, hold_vec);
         end
         hold_pend = 1'b0;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (sb.size() == 0) fail("unexpected_output", out_vec, 64'h0);
            else begin
               e = sb.pop_front();
               pops++;
               if (out_vec !== e.exp) fail("model_out", out_vec, e.exp);
               if (lat_chk && (cyc - e.acc != 3)) fail("latency", 64'(cyc - e.acc), 64'd3);
               if (sweep_on) begin
                  for (int l = 0; l < DIM; l++) begin
                     xi = int'($signed(e.vin[l*16 +: 16]));
                     yi = int'($signed(out_vec[l*16 +: 16]));
                     if (e.m == 2'd0) begin
                        id = rnd($tanh(real'(xi) / 256.0) * 256.0);
                        tanh_res[e.vin[l*16 +: 16]] = out_vec[l*16 +: 16];
                        err = (yi > id) ? yi - id : id - yi;
                        if (err > max_err_t) max_err_t = err;
                     end else begin
                        id = rnd(256.0 / (1.0 + $exp(-real'(xi) / 256.0)));
                        err = (yi > id) ? yi - id : id - yi;
                        if (err > max_err_s) max_err_s = err;
                     end
                  end
               end
            end
         end else if (out_valid === 1'b1) begin
            hold_pend = 1'b1;
            hold_vec  = out_vec;
         end
         if (in_valid && in_ready === 1'b1) begin
            e.vin = in_vec;
            e.m   = in_mode;
            e.acc = cyc + 1;
            for (int l = 0; l < DIM; l++) e.exp[l*16 +: 16] = model(in_mode, in_vec[l*16 +: 16]);
            sb.push_back(e);
         end
      end
   end

   // Random downstream stalls while enabled
   initial forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Present a beat and return one time unit after the edge that took it
   task automatic put(input logic [1:0] m, input logic [63:0] v, output int waits);
      in_valid = 1'b1; in_mode = m; in_vec = v; waits = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waits < 200) begin @(negedge clk); waits++; end
      if (in_ready !== 1'b1) begin checks++; fail("put_timeout", 64'(waits), 64'd0); end
      @(posedge clk); #1;
   endtask

   task automatic one(input logic [1:0] m, input logic [63:0] v, input logic [63:0] req, input string nm);
      int w, n;
      put(m, v, w);
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (n != 3) fail({nm, "_latency"}, 64'(n), 64'd3);
      checks++; if (out_vec !== req) fail(nm, out_vec, req);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
      #1;
      checks++; if (sb.size() != 0) fail("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int          w, p0;
      logic [63:0] v;
      logic [15:0] s;
      int          asym;
      for (int k = 0; k < 32; k++) nodes[k] = rnd($tanh(real'(k) / 8.0) * 256.0);
      nodes[32] = 256;

      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      checks++; if (out_valid !== 1'b0) fail("reset_out_valid", 64'(out_valid), 64'd0);
      checks++; if (out_vec !== 64'h0) fail("reset_out_vec", out_vec, 64'h0);
      checks++; if (in_ready !== 1'b1) fail("reset_in_ready", 64'(in_ready), 64'd1);

      // Directed literals
      lat_chk = 1'b1;
      one(2'd0, 64'h7FFF_FF00_0100_0000, 64'h0100_FF3D_00C3_0000, "tanh_dir");
      one(2'd1, 64'h8000_F800_0800_0000, 64'h0000_0000_0100_0080, "sigmoid_dir");
      one(2'd2, 64'h7FFF_8000_0123_FFFB, 64'h7FFF_8000_0123_FFFB, "identity_dir");
      one(2'd3, 64'h7FFF_8000_0123_FFFB, 64'h7FFF_0000_0123_0000, "relu_dir");

      // Reset with three beats in flight
      out_ready = 1'b0;
      p0 = pops;
      put(2'd0, 64'h0100_0100_0100_0100, w);
      put(2'd1, 64'h0800_0800_0800_0800, w);
      put(2'd3, 64'h0123_0123_0123_0123, w);
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      checks++; if (out_valid !== 1'b0) fail("midreset_out_valid", 64'(out_valid), 64'd0);
      checks++; if (out_vec !== 64'h0) fail("midreset_out_vec", out_vec, 64'h0);
      checks++; if (in_ready !== 1'b1) fail("midreset_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (pops != p0) fail("midreset_flush", 64'(pops - p0), 64'd0);

      // Backpressure stream, mixed modes
      lat_chk = 1'b0; rand_rdy = 1'b1; p0 = pops;
      for (int i = 0; i < 10; i++) begin
         for (int l = 0; l < DIM; l++) v[l*16 +: 16] = 16'(-700 + i * 150 + l * 37);
         put(2'(i % 4), v, w);
      end
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      @(posedge clk); #2; out_ready = 1'b1;
      drain();
      checks++; if (pops - p0 != 10) fail("stream_count", 64'(pops - p0), 64'd10);

      // Full throughput
      lat_chk = 1'b1; p0 = pops;
      for (int i = 0; i < 100; i++) begin
         for (int l = 0; l < DIM; l++) v[l*16 +: 16] = 16'(i * 311 - 15000 + l * 1000);
         put(2'(i % 4), v, w);
         checks++; if (w != 0) fail("thru_in_ready", 64'(w), 64'd0);
      end
      in_valid = 1'b0;
      drain();
      checks++; if (pops - p0 != 100) fail("thru_count", 64'(pops - p0), 64'd100);

      // Exhaustive sweep, tanh then sigmoid
      sweep_on = 1'b1;
      for (int m = 0; m < 2; m++) begin
         for (int b = 0; b < 16384; b++) begin
            for (int l = 0; l < DIM; l++) v[l*16 +: 16] = 16'(b * 4 + l);
            put(2'(m), v, w);
         end
      end
      in_valid = 1'b0;
      drain();
      sweep_on = 1'b0;
      checks++; if (max_err_t > 2) fail("tanh_max_err", 64'(max_err_t), 64'd2);
      checks++; if (max_err_s > 1) fail("sigmoid_max_err", 64'(max_err_s), 64'd1);
      asym = 0;
      for (int x = 1; x < 32768; x++) begin
         s = tanh_res[x] + tanh_res[65536 - x];
         if (s != 16'h0) asym++;
      end
      checks++; if (asym != 0) fail("tanh_symmetry", 64'(asym), 64'd0);
      checks++; if (tanh_res[0] !== 16'h0) fail("tanh_zero", 64'(tanh_res[0]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
